frame_writer: RTL and testbench

Downstream stage of the ray-cast pixel pipeline (GEN_RAY → INTERSECT → PHONG → SET_PIXEL). Accepts shaded pixels over a valid/ready stream and buffers them in a small FIFO. Converts (x,y) into a linear framebuffer address and issues held write requests to the render/SRAM arbiter. At frame end it waits for display vsync, then swaps the double-buffer offsets.

---
 rtl/frame_writer.sv | 240 ++++++++++++++++++++++++
 tb/tb_frame_writer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// frame_writer: last stage of the ray-cast pixel pipeline.
// Buffers shaded pixels in a small FIFO, turns (x,y) into a linear
// framebuffer word address, issues held SRAM write requests, and at frame
// end waits for display vsync before swapping the double-buffer offsets.
module frame_writer #(
    parameter int H_RES      = 800,
    parameter int V_RES      = 600,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic [23:0]       pix_rgb,
    input  logic              pix_last,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_wr_addr,
    output logic [31:0]       sram_wr_data,
    input  logic              sram_wr_ack,
    input  logic              vsync_pulse,
    output logic              rd_addr_offset,
    output logic              wr_addr_offset,
    output logic              frame_done,
    output logic              range_err
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [9:0]        X_LIM    = 10'(H_RES);
    localparam logic [9:0]        Y_LIM    = 10'(V_RES);
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] H_RES_W  = ADDR_W'(H_RES);

    // One FIFO slot. no_write marks an out-of-range last pixel that only
    // closes the frame and never reaches the SRAM.
    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
        logic        last;
        logic        no_write;
    } entry_t;

    // IDLE/LOAD/WRITE together form the RUN phase of the frame.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_WAIT_SWAP
    } state_t;

    entry_t            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_alive;

    logic [9:0]        r_head_x;
    logic [9:0]        r_head_y;
    logic [23:0]       r_head_rgb;
    logic              r_head_last;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_wr_off;
    logic              r_frame_done;
    logic              r_range_err;

    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_in_range;
    logic              w_push;
    logic              w_pop;
    logic              w_capture;
    logic              w_issue;
    logic              w_swap;
    entry_t            w_new;
    entry_t            w_head;
    logic [ADDR_W-1:0] w_y_ext;
    logic [ADDR_W-1:0] w_x_ext;
    logic [ADDR_W-1:0] w_addr;

    // Ready depends only on registers, so there is no path from pix_valid.
    assign w_full     = (r_count == CNT_FULL);
    assign w_empty    = (r_count == '0);
    assign pix_ready  = r_alive && !w_full;
    assign w_accept   = pix_valid && pix_ready;
    assign w_in_range = (pix_x < X_LIM) && (pix_y < Y_LIM);
    // Out-of-range pixels are swallowed unless they carry the frame end.
    assign w_push     = w_accept && (w_in_range || pix_last);
    assign w_new      = '{x: pix_x, y: pix_y, rgb: pix_rgb,
                          last: pix_last, no_write: !w_in_range};
    assign w_head     = r_mem[r_rd_ptr];

    // y*H_RES + x from the captured head; for 800 columns this is
    // y*512 + y*256 + y*32 + x, which never exceeds 479999.
    assign w_y_ext = ADDR_W'(r_head_y);
    assign w_x_ext = ADDR_W'(r_head_x);
    assign w_addr  = (H_RES == 800)
                   ? ((w_y_ext << 9) + (w_y_ext << 8) + (w_y_ext << 5) + w_x_ext)
                   : (w_y_ext * H_RES_W + w_x_ext);

    // Hold pix_ready low while in reset, raise it on the first clock after.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_alive <= 1'b0;
        else          r_alive <= 1'b1;
    end

    // FIFO storage write port.
    // NOTE: the storage array is deliberately not reset; a slot is only read
    // after the pointers say it was written, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_new;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Writer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state plus pop/capture/issue/swap strobes.
    // NOTE: every signal gets a default first so no branch leaves a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_issue     = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    if (w_head.no_write) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_WAIT_SWAP;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                w_issue     = 1'b1;
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                // The head leaves the FIFO only when the arbiter takes it.
                if (sram_wr_ack) begin
                    w_pop       = 1'b1;
                    w_state_nxt = r_head_last ? ST_WAIT_SWAP : ST_IDLE;
                end
            end
            ST_WAIT_SWAP: begin
                if (vsync_pulse) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered copy of the FIFO head feeding the address arithmetic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head_x    <= '0;
            r_head_y    <= '0;
            r_head_rgb  <= '0;
            r_head_last <= 1'b0;
        end else if (w_capture) begin
            r_head_x    <= w_head.x;
            r_head_y    <= w_head.y;
            r_head_rgb  <= w_head.rgb;
            r_head_last <= w_head.last;
        end
    end

    // SRAM request held stable from issue until the acknowledging edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_issue) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_addr;
            r_wr_data <= {8'h00, r_head_rgb};
        end else if (r_state == ST_WRITE && sram_wr_ack) begin
            r_wr_en   <= 1'b0;
        end
    end

    // Buffer swap, frame-done strobe and sticky range error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_off     <= 1'b1;
            r_frame_done <= 1'b0;
            r_range_err  <= 1'b0;
        end else begin
            r_frame_done <= w_swap;
            if (w_swap)                   r_wr_off    <= ~r_wr_off;
            if (w_accept && !w_in_range)  r_range_err <= 1'b1;
        end
    end

    assign sram_wr_en     = r_wr_en;
    assign sram_wr_addr   = r_wr_addr;
    assign sram_wr_data   = r_wr_data;
    assign wr_addr_offset = r_wr_off;
    assign rd_addr_offset = ~r_wr_off;
    assign frame_done     = r_frame_done;
    assign range_err      = r_range_err;

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: reset values, latency, a vector
// table of address cases, held-request stability, FIFO fill, random traffic
// against an arithmetic model, vsync-gated buffer swap and reset mid-write.
module tb_frame_writer;

    localparam int H_RES  = 800;
    localparam int V_RES  = 600;
    localparam int ADDR_W = 19;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              pix_valid = 1'b0;
    logic [9:0]        pix_x = '0;
    logic [9:0]        pix_y = '0;
    logic [23:0]       pix_rgb = '0;
    logic              pix_last = 1'b0;
    logic              vsync_pulse = 1'b0;
    logic              sram_wr_ack;
    logic              pix_ready;
    logic              sram_wr_en;
    logic [ADDR_W-1:0] sram_wr_addr;
    logic [31:0]       sram_wr_data;
    logic              rd_addr_offset;
    logic              wr_addr_offset;
    logic              frame_done;
    logic              range_err;

    frame_writer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_rgb        (pix_rgb),
        .pix_last       (pix_last),
        .sram_wr_en     (sram_wr_en),
        .sram_wr_addr   (sram_wr_addr),
        .sram_wr_data   (sram_wr_data),
        .sram_wr_ack    (sram_wr_ack),
        .vsync_pulse    (vsync_pulse),
        .rd_addr_offset (rd_addr_offset),
        .wr_addr_offset (wr_addr_offset),
        .frame_done     (frame_done),
        .range_err      (range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic [9:0]        x;
        logic [9:0]        y;
        logic [23:0]       rgb;
        logic              writes;
        logic [ADDR_W-1:0] addr;
        logic              rerr;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  obs_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   ack_mode = 0;    // 0 high, 1 low, 2 delayed, 3 random, 4 manual
    int   ack_delay = 5;
    logic manual_ack = 1'b0;
    int   stall_cnt = 0;
    int   frame_cnt = 0;
    logic exp_rerr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    // Offer one pixel, wait (bounded) for acceptance, update the model.
    task automatic send(input logic [9:0] x, input logic [9:0] y,
                        input logic [23:0] rgb, input logic last);
        int  n;
        wr_t w;
        n = 0;
        pix_valid = 1'b1;
        pix_x     = x;
        pix_y     = y;
        pix_rgb   = rgb;
        pix_last  = last;
        while (!pix_ready && n < 200) begin
            tick();
            n++;
        end
        if (!pix_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            pix_valid = 1'b0;
            pix_last  = 1'b0;
            return;
        end
        stall_cnt += n;
        @(posedge clk);
        if (int'(x) < H_RES && int'(y) < V_RES) begin
            w.addr = ADDR_W'(int'(y) * H_RES + int'(x));
            w.data = {8'h00, rgb};
            exp_q.push_back(w);
        end else begin
            exp_rerr = 1'b1;
        end
        #1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int t;
        t = 0;
        while (obs_q.size() < n && t < 3000) begin
            tick();
            t++;
        end
        check("write_count", 32'(obs_q.size()), 32'(n));
    endtask

    task automatic wait_wr_en();
        int t;
        t = 0;
        while (!sram_wr_en && t < 20) begin
            tick();
            t++;
        end
        check("wr_en_rise", 32'(sram_wr_en), 32'd1);
    endtask

    task automatic compare_model(input string tag);
        int n;
        wr_t e;
        wr_t o;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q[i];
            o = obs_q[i];
            check({tag, "_addr"}, 32'(o.addr), 32'(e.addr));
            check({tag, "_data"}, o.data, e.data);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Arbiter model: drives the ack according to ack_mode.
    initial begin
        int cnt;
        cnt = 0;
        sram_wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ack_mode)
                0: sram_wr_ack = 1'b1;
                1: sram_wr_ack = 1'b0;
                2: begin
                    if (!sram_wr_en) cnt = 0;
                    sram_wr_ack = sram_wr_en && (cnt >= ack_delay);
                    if (sram_wr_en) cnt = sram_wr_ack ? 0 : cnt + 1;
                end
                3: sram_wr_ack = ($urandom_range(0, 2) == 0);
                default: sram_wr_ack = manual_ack;
            endcase
        end
    end

    // Write monitor: records accepted writes, checks held requests stay put.
    initial begin
        logic              p_en;
        logic              p_ack;
        logic [ADDR_W-1:0] p_addr;
        logic [31:0]       p_data;
        wr_t               w;
        p_en   = 1'b0;
        p_ack  = 1'b0;
        p_addr = '0;
        p_data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                p_en = 1'b0;
            end else begin
                if (p_en && !p_ack) begin
                    check("wr_en_held", 32'(sram_wr_en), 32'd1);
                    check("addr_stable", 32'(sram_wr_addr), 32'(p_addr));
                    check("data_stable", sram_wr_data, p_data);
                end
                if (sram_wr_en && sram_wr_ack) begin
                    w.addr = sram_wr_addr;
                    w.data = sram_wr_data;
                    obs_q.push_back(w);
                end
                if (frame_done) frame_cnt++;
                p_en   = sram_wr_en;
                p_ack  = sram_wr_ack;
                p_addr = sram_wr_addr;
                p_data = sram_wr_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000 ns");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        int   f0;

        vecs[0] = '{10'd0,    10'd0,    24'hA1B2C3, 1'b1, 19'd0,      1'b0};
        vecs[1] = '{10'd799,  10'd0,    24'h010203, 1'b1, 19'd799,    1'b0};
        vecs[2] = '{10'd0,    10'd1,    24'h445566, 1'b1, 19'd800,    1'b0};
        vecs[3] = '{10'd100,  10'd300,  24'h778899, 1'b1, 19'd240100, 1'b0};
        vecs[4] = '{10'd512,  10'd511,  24'hABCDEF, 1'b1, 19'd409312, 1'b0};
        vecs[5] = '{10'd5,    10'd599,  24'h5A5A5A, 1'b1, 19'd479205, 1'b0};
        vecs[6] = '{10'd800,  10'd0,    24'hDEAD00, 1'b0, 19'd0,      1'b1};
        vecs[7] = '{10'd5,    10'd0,    24'h00BEEF, 1'b1, 19'd5,      1'b1};
        vecs[8] = '{10'd0,    10'd600,  24'h123123, 1'b0, 19'd0,      1'b1};
        vecs[9] = '{10'd1023, 10'd1023, 24'hFFFFFF, 1'b0, 19'd0,      1'b1};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_wr_en", 32'(sram_wr_en), 32'd0);
        check("rst_wr_addr", 32'(sram_wr_addr), 32'd0);
        check("rst_wr_data", sram_wr_data, 32'd0);
        check("rst_rd_off", 32'(rd_addr_offset), 32'd0);
        check("rst_wr_off", 32'(wr_addr_offset), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_range_err", 32'(range_err), 32'd0);
        reset_n = 1'b1;
        tick();
        check("ready_after_reset", 32'(pix_ready), 32'd1);

        // Single pixel latency with ack tied high.
        ack_mode = 0;
        send(10'd3, 10'd2, 24'h123456, 1'b0);
        check("lat_n0_wr_en", 32'(sram_wr_en), 32'd0);
        tick();
        check("lat_n1_wr_en", 32'(sram_wr_en), 32'd0);
        tick();
        check("lat_n2_wr_en", 32'(sram_wr_en), 32'd1);
        check("lat_n2_addr", 32'(sram_wr_addr), 32'd1603);
        check("lat_n2_data", sram_wr_data, 32'h00123456);
        tick();
        check("lat_n3_wr_en", 32'(sram_wr_en), 32'd0);
        wait_cycles(4);
        check("lat_one_write", 32'(obs_q.size()), 32'd1);
        exp_q.delete();
        obs_q.delete();

        // Address vector table, including out-of-range drops.
        for (int i = 0; i < 10; i++) begin
            obs_q.delete();
            send(vecs[i].x, vecs[i].y, vecs[i].rgb, 1'b0);
            wait_cycles(6);
            check("tbl_count", 32'(obs_q.size()), vecs[i].writes ? 32'd1 : 32'd0);
            if (vecs[i].writes && obs_q.size() > 0) begin
                check("tbl_addr", 32'(obs_q[0].addr), 32'(vecs[i].addr));
                check("tbl_data", obs_q[0].data, {8'h00, vecs[i].rgb});
            end
            check("tbl_range_err", 32'(range_err), 32'(vecs[i].rerr));
        end
        exp_q.delete();
        obs_q.delete();

        // Each write acknowledged five cycles late.
        ack_mode  = 2;
        stall_cnt = 0;
        for (int i = 0; i < 4; i++)
            send(10'(40 * i + 1), 10'(7 * i + 2), 24'($urandom), 1'b0);
        check("delay_no_stall", 32'(stall_cnt), 32'd0);
        check("delay_ready", 32'(pix_ready), 32'd1);
        wait_writes(4);
        compare_model("delay");

        // Fill the FIFO with ack held low, then drain.
        ack_mode  = 1;
        stall_cnt = 0;
        for (int i = 0; i < 16; i++)
            send(10'($urandom_range(0, 799)), 10'($urandom_range(0, 599)), 24'($urandom), 1'b0);
        check("fill_no_stall", 32'(stall_cnt), 32'd0);
        check("fill_ready_low", 32'(pix_ready), 32'd0);
        tick();
        check("fill_ready_still_low", 32'(pix_ready), 32'd0);
        check("fill_wr_en_held", 32'(sram_wr_en), 32'd1);
        ack_mode = 0;
        for (int i = 0; i < 4; i++)
            send(10'($urandom_range(0, 799)), 10'($urandom_range(0, 599)), 24'($urandom), 1'b0);
        wait_writes(20);
        compare_model("fill");

        // Random traffic with random ack against the arithmetic model.
        ack_mode = 3;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0)
                send(10'($urandom_range(800, 1023)), 10'($urandom_range(0, 1023)), 24'($urandom), 1'b0);
            else
                send(10'($urandom_range(0, 799)), 10'($urandom_range(0, 599)), 24'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_writes(exp_q.size());
        wait_cycles(5);
        compare_model("rand");
        check("rand_range_err", 32'(range_err), 32'(exp_rerr));

        // Corner pixel closes the frame; vsync on the ack cycle is ignored.
        ack_mode   = 4;
        manual_ack = 1'b0;
        f0 = frame_cnt;
        send(10'd799, 10'd599, 24'hFFEEDD, 1'b1);
        wait_wr_en();
        check("corner_addr", 32'(sram_wr_addr), 32'd479999);
        manual_ack  = 1'b1;
        vsync_pulse = 1'b1;
        tick();
        manual_ack  = 1'b0;
        vsync_pulse = 1'b0;
        check("corner_wr_en_drop", 32'(sram_wr_en), 32'd0);
        check("vsync_on_ack_ignored", 32'(frame_done), 32'd0);
        check("vsync_on_ack_wr_off", 32'(wr_addr_offset), 32'd1);
        send(10'd10, 10'd10, 24'h0A0B0C, 1'b0);
        wait_cycles(6);
        check("wait_swap_no_write", 32'(obs_q.size()), 32'd1);
        check("wait_swap_no_done", 32'(frame_done), 32'd0);
        check("wait_swap_rd_off", 32'(rd_addr_offset), 32'd0);
        ack_mode    = 0;
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        check("swap_frame_done", 32'(frame_done), 32'd1);
        check("swap_wr_off", 32'(wr_addr_offset), 32'd0);
        check("swap_rd_off", 32'(rd_addr_offset), 32'd1);
        tick();
        check("swap_done_one_cycle", 32'(frame_done), 32'd0);
        check("swap_pulse_count", 32'(frame_cnt - f0), 32'd1);
        wait_writes(2);
        compare_model("frame");

        // Out-of-range last pixel still closes the frame.
        f0 = frame_cnt;
        send(10'd900, 10'd10, 24'h111111, 1'b1);
        wait_cycles(4);
        check("marker_range_err", 32'(range_err), 32'd1);
        check("marker_no_swap_yet", 32'(wr_addr_offset), 32'd0);
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        check("marker_frame_done", 32'(frame_done), 32'd1);
        check("marker_wr_off", 32'(wr_addr_offset), 32'd1);
        check("marker_rd_off", 32'(rd_addr_offset), 32'd0);
        wait_cycles(2);
        check("marker_pulse_count", 32'(frame_cnt - f0), 32'd1);
        check("marker_no_write", 32'(obs_q.size()), 32'd0);
        send(10'd2, 10'd3, 24'h223344, 1'b0);
        wait_writes(1);
        compare_model("marker");

        // Reset while a request is pending.
        ack_mode = 1;
        send(10'd20, 10'd20, 24'h777777, 1'b0);
        wait_wr_en();
        reset_n = 1'b0;
        #1;
        check("midrst_wr_en", 32'(sram_wr_en), 32'd0);
        check("midrst_addr", 32'(sram_wr_addr), 32'd0);
        check("midrst_data", sram_wr_data, 32'd0);
        check("midrst_ready", 32'(pix_ready), 32'd0);
        check("midrst_range_err", 32'(range_err), 32'd0);
        check("midrst_wr_off", 32'(wr_addr_offset), 32'd1);
        check("midrst_rd_off", 32'(rd_addr_offset), 32'd0);
        exp_q.delete();
        obs_q.delete();
        exp_rerr = 1'b0;
        tick();
        reset_n  = 1'b1;
        ack_mode = 0;
        tick();
        check("postrst_ready", 32'(pix_ready), 32'd1);
        send(10'd7, 10'd1, 24'hC0FFEE, 1'b0);
        wait_writes(1);
        compare_model("postrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
